// File: rtl/twitch_mem_pkg.sv
// Shared encodings and helpers for twitch_mem: access sizes, FSM states,
// byte-lane mask generation and load result extension.
package twitch_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W0,
        ST_W1,
        ST_FIN
    } state_t;

    // Size code 11 behaves as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Returns {second-word enables, first-word enables}.
    function automatic logic [7:0] lane_mask(input logic [1:0] addr_lo, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'b0000_0001;
            SZ_HALF: base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << addr_lo;
    endfunction

    function automatic logic crosses(input logic [1:0] addr_lo, input logic [1:0] size);
        return ({1'b0, addr_lo} + size_bytes(size)) > 3'd4;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {{24{~uns & raw[7]}}, raw[7:0]};
            SZ_HALF: res = {{16{~uns & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/twitch_mem_bank.sv
// Word array with byte-lane writes: a registered fetch read port and a
// read-before-write data port.
module twitch_mem_bank #(
    parameter int    AW        = 12,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          i_srst,
    input  logic          i_f_en,
    input  logic [AW-1:0] i_f_addr,
    output logic [31:0]   o_f_q,
    input  logic [AW-1:0] i_d_addr,
    input  logic [3:0]    i_d_be,
    input  logic [31:0]   i_d_wdata,
    output logic [31:0]   o_d_q
);

    logic [31:0] r_mem [2**AW];
    logic [31:0] r_f_q;
    logic [31:0] r_d_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_d_be[i]) begin
                r_mem[i_d_addr][i*8 +: 8] <= i_d_wdata[i*8 +: 8];
            end
        end
        r_d_q <= r_mem[i_d_addr];
    end

    // Fetch output holds its last word while no fetch is requested.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_f_q <= '0;
        end else if (i_f_en) begin
            r_f_q <= r_mem[i_f_addr];
        end
    end

    assign o_f_q = r_f_q;
    assign o_d_q = r_d_q;

endmodule

// File: rtl/twitch_mem.sv
// Unified instruction/data memory with sized, sign/zero-extended, auto-split
// data accesses. Define MISALIGN_TRAP_EN to fault word-crossing accesses instead.
module twitch_mem
    import twitch_mem_pkg::*;
#(
    parameter int    ADDR_W    = 14,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_data,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_busy,
    output logic              d_fault
);

    localparam int WA_W = ADDR_W - 2;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_uns;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word0;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_valid;

    logic              w_accept;
    logic              w_cross;
    logic              w_trap;
    logic              w_trap_in;
    logic [7:0]        w_mask;
    logic [WA_W-1:0]   w_word_a;
    logic [WA_W-1:0]   w_word_b;
    logic [WA_W-1:0]   w_bank_addr;
    logic [3:0]        w_bank_be;
    logic [31:0]       w_bank_q;
    logic [31:0]       w_wlanes;
    logic [31:0]       w_ld_word;
    logic [55:0]       w_buf;
    logic              w_unused;

    assign w_mask   = lane_mask(r_addr[1:0], r_size);
    assign w_cross  = |w_mask[7:4];
    assign w_word_a = r_addr[ADDR_W-1:2];
    assign w_word_b = w_word_a + WA_W'(1);
    assign w_accept = (r_state == ST_IDLE) && !r_done && d_req;
    assign w_unused = &{1'b0, i_addr[1:0]};

`ifdef MISALIGN_TRAP_EN
    logic r_trap;
    logic r_fault;

    assign w_trap_in = crosses(d_addr[1:0], d_size);

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_trap  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_trap <= w_trap_in;
            end
            r_fault <= (r_state == ST_FIN) && r_trap;
        end
    end

    assign w_trap  = r_trap;
    assign d_fault = r_fault;
`else
    assign w_trap_in = 1'b0;
    assign w_trap    = 1'b0;
    assign d_fault   = 1'b0;
`endif

    // Store byte k of the word sits in lane (addr_lo + k) mod 4 of both words;
    // load bytes are picked from the {second, first} word pair starting at addr_lo.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_wlanes[gi*8 +: 8]  = r_wdata[8*((gi - int'(r_addr[1:0])) & 3) +: 8];
        assign w_ld_word[gi*8 +: 8] = w_buf[8*(gi + int'(r_addr[1:0])) +: 8];
    end

    assign w_buf = w_cross ? {w_bank_q[23:0], r_word0} : {24'b0, w_bank_q};

    always_comb begin
        w_state_next = r_state;
        w_bank_addr  = w_word_a;
        w_bank_be    = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_trap_in ? ST_FIN : ST_W0;
                end
            end
            ST_W0: begin
                w_state_next = w_cross ? ST_W1 : ST_FIN;
                if (r_we) begin
                    w_bank_be = w_mask[3:0];
                end
            end
            ST_W1: begin
                w_state_next = ST_FIN;
                w_bank_addr  = w_word_b;
                if (r_we) begin
                    w_bank_be = w_mask[7:4];
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // A reset landing on W1 must drop the pending upper lanes.
        if (resetn) begin
            w_bank_be = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= d_addr;
            r_size  <= d_size;
            r_we    <= d_we;
            r_uns   <= d_unsigned;
            r_wdata <= d_wdata;
        end
        if (r_state == ST_W1) begin
            r_word0 <= w_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_done  <= 1'b0;
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else begin
            r_done  <= (r_state == ST_FIN);
            r_valid <= i_req;
            if ((r_state == ST_FIN) && !r_we && !w_trap) begin
                r_rdata <= load_extend(w_ld_word, r_size, r_uns);
            end
        end
    end

    twitch_mem_bank #(
        .AW        (WA_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk       (clk),
        .i_srst    (resetn),
        .i_f_en    (i_req),
        .i_f_addr  (i_addr[ADDR_W-1:2]),
        .o_f_q     (i_data),
        .i_d_addr  (w_bank_addr),
        .i_d_be    (w_bank_be),
        .i_d_wdata (w_wlanes),
        .o_d_q     (w_bank_q)
    );

    assign i_valid = r_valid;
    assign d_rdata = r_rdata;
    assign d_done  = r_done;
    assign d_busy  = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_twitch_mem.sv
// Directed bench for twitch_mem: expected completions are queued as each
// access is issued and compared when d_done arrives.
module tb_twitch_mem;

    localparam int         AW = 14;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        int          lat;
        logic        fault;
    } sb_item_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_data;
    logic          i_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [1:0]    d_size;
    logic          d_unsigned;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic          d_busy;
    logic          d_fault;

    sb_item_t    sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt;
    logic [31:0] exp_rd = 32'h0;

    always #5 clk = ~clk;

    twitch_mem #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .d_busy     (d_busy),
        .d_fault    (d_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one data access; poke keeps a store request asserted while busy,
    // fetch_chk fetches the accessed word during W0 and checks old/new data.
    task automatic access(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_lat, input logic exp_fault,
                          input logic poke, input logic fetch_chk,
                          input logic [31:0] f_old, input logic [31:0] f_new);
        sb_item_t it;
        int cyc;
        it.tag   = tag;
        it.lat   = exp_lat;
        it.fault = exp_fault;
        it.rdata = (we || exp_fault) ? exp_rd : exp_data;
        sb_q.push_back(it);
        exp_rd = it.rdata;

        d_req = 1'b1; d_we = we; d_addr = addr; d_size = size;
        d_unsigned = uns; d_wdata = wdata;
        @(posedge clk); #1;
        d_req = poke;
        if (poke) begin
            d_we    = 1'b1;
            d_wdata = 32'h0;
        end
        if (fetch_chk) begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        check({tag, "/busy_start"}, 32'(d_busy), 32'd1);
        cyc = 0;
        while (d_done !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (fetch_chk && cyc == 1) check({tag, "/fetch_old"}, i_data, f_old);
            if (fetch_chk && cyc == 2) begin
                check({tag, "/fetch_new"}, i_data, f_new);
                i_req = 1'b0;
            end
        end
        d_req = 1'b0;
        it = sb_q.pop_front();
        check({it.tag, "/latency"}, 32'(cyc), 32'(it.lat));
        check({it.tag, "/rdata"}, d_rdata, it.rdata);
        check({it.tag, "/fault"}, 32'(d_fault), 32'(it.fault));
        check({it.tag, "/busy_done"}, 32'(d_busy), 32'd1);
        @(posedge clk); #1;
        check({it.tag, "/busy_end"}, 32'(d_busy), 32'd0);
        $display("txn %-14s we=%0d addr=%h size=%0d rdata=%h lat=%0d fault=%0d",
                 it.tag, we, addr, size, d_rdata, cyc, d_fault);
    endtask

    initial begin
        resetn = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = SW; d_unsigned = 1'b0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/d_done",  32'(d_done),  32'd0);
        check("reset/d_busy",  32'(d_busy),  32'd0);
        check("reset/d_fault", 32'(d_fault), 32'd0);
        check("reset/i_valid", 32'(i_valid), 32'd0);
        check("reset/d_rdata", d_rdata, 32'h0);
        check("reset/i_data",  i_data,  32'h0);
        resetn = 1'b0;
        @(posedge clk); #1;

        access("st_w_100",   1, 14'h100, SW, 0, 32'hDEADBEEF, 32'h0,       2, 0, 0, 0, 0, 0);
        access("ld_w_poke",  0, 14'h100, SW, 0, 32'h0,       32'hDEADBEEF, 2, 0, 1, 0, 0, 0);
        access("ld_w_100",   0, 14'h100, SW, 0, 32'h0,       32'hDEADBEEF, 2, 0, 0, 0, 0, 0);
        access("ld_sb_103",  0, 14'h103, SB, 0, 32'h0,       32'hFFFFFFDE, 2, 0, 0, 0, 0, 0);
        access("ld_ub_103",  0, 14'h103, SB, 1, 32'h0,       32'h000000DE, 2, 0, 0, 0, 0, 0);
        access("ld_sh_102",  0, 14'h102, SH, 0, 32'h0,       32'hFFFFDEAD, 2, 0, 0, 0, 0, 0);
        access("ld_uh_100",  0, 14'h100, SH, 1, 32'h0,       32'h0000BEEF, 2, 0, 0, 0, 0, 0);
        access("ld_uh_101",  0, 14'h101, SH, 1, 32'h0,       32'h0000ADBE, 2, 0, 0, 0, 0, 0);

        access("st_w_1fc",   1, 14'h1FC, SW, 0, 32'hCAFEF00D, 32'h0,       2, 0, 0, 0, 0, 0);
        access("st_w_200",   1, 14'h200, SW, 0, 32'h0BADC0DE, 32'h0,       2, 0, 0, 0, 0, 0);
        access("st_w_1fe",   1, 14'h1FE, SW, 0, 32'h11223344, 32'h0,       TRAP ? 1 : 3, TRAP, 0, 0, 0, 0);
        access("ld_ub_1fe",  0, 14'h1FE, SB, 1, 32'h0, TRAP ? 32'hFE : 32'h44, 2, 0, 0, 0, 0, 0);
        access("ld_ub_1ff",  0, 14'h1FF, SB, 1, 32'h0, TRAP ? 32'hCA : 32'h33, 2, 0, 0, 0, 0, 0);
        access("ld_ub_200",  0, 14'h200, SB, 1, 32'h0, TRAP ? 32'hDE : 32'h22, 2, 0, 0, 0, 0, 0);
        access("ld_ub_201",  0, 14'h201, SB, 1, 32'h0, TRAP ? 32'hC0 : 32'h11, 2, 0, 0, 0, 0, 0);
        access("ld_w_1fc",   0, 14'h1FC, SW, 0, 32'h0, TRAP ? 32'hCAFEF00D : 32'h3344F00D, 2, 0, 0, 0, 0, 0);
        access("ld_w_200",   0, 14'h200, SW, 0, 32'h0, TRAP ? 32'h0BADC0DE : 32'h0BAD1122, 2, 0, 0, 0, 0, 0);
        access("ld_w_1fe",   0, 14'h1FE, SW, 0, 32'h0, 32'h11223344, TRAP ? 1 : 3, TRAP, 0, 0, 0, 0);

        access("st_b_3fff",  1, 14'h3FFF, SB, 0, 32'h77,   32'h0, 2, 0, 0, 0, 0, 0);
        access("st_b_0000",  1, 14'h0000, SB, 0, 32'h66,   32'h0, 2, 0, 0, 0, 0, 0);
        access("st_h_3fff",  1, 14'h3FFF, SH, 0, 32'hA55A, 32'h0, TRAP ? 1 : 3, TRAP, 0, 0, 0, 0);
        access("ld_ub_3fff", 0, 14'h3FFF, SB, 1, 32'h0, TRAP ? 32'h77 : 32'h5A, 2, 0, 0, 0, 0, 0);
        access("ld_ub_0000", 0, 14'h0000, SB, 1, 32'h0, TRAP ? 32'h66 : 32'hA5, 2, 0, 0, 0, 0, 0);
        access("ld_sh_3fff", 0, 14'h3FFF, SH, 0, 32'h0, 32'hFFFFA55A, TRAP ? 1 : 3, TRAP, 0, 0, 0, 0);

        access("st_w_fetch", 1, 14'h100, SW, 0, 32'h12345678, 32'h0, 2, 0, 0, 1,
               32'hDEADBEEF, 32'h12345678);
        check("fetch/i_valid_low", 32'(i_valid), 32'd0);
        check("fetch/i_data_hold", i_data, 32'h12345678);

        // Reset during W1 of a crossing load (FIN when crossing traps).
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h1FE; d_size = SW; d_unsigned = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b0;
        if (!TRAP) begin
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        exp_rd = 32'h0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (d_done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        check("rst_mid/done_pulses", 32'(done_cnt), 32'd0);
        check("rst_mid/d_busy", 32'(d_busy), 32'd0);
        check("rst_mid/d_rdata", d_rdata, 32'h0);
        $display("txn rst_mid        done_pulses=%0d busy=%0d", done_cnt, d_busy);
        access("ld_after_rst", 0, 14'h100, SW, 0, 32'h0, 32'h12345678, 2, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
